// File: rtl/haze_load_pkg.sv
// Shared types and helpers for the load return path formatter.
package haze_load_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        RESP  = 2'd3
    } load_state_e;

    // True for the five load encodings the formatter understands.
    function automatic logic f_is_legal(input logic [2:0] funct3);
        logic legal;
        case (funct3)
            LB, LH, LW, LBU, LHU: legal = 1'b1;
            default:              legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True when the access runs past the end of the first word and needs beat 2.
    function automatic logic f_spans(input logic [2:0] funct3, input logic [1:0] addrlo);
        logic spans;
        case (funct3)
            LH, LHU: spans = (addrlo == 2'd3);
            LW:      spans = (addrlo != 2'd0);
            default: spans = 1'b0;
        endcase
        return spans;
    endfunction

endpackage

// File: rtl/extender_NtoM.sv
// Widens an N-bit value to M bits with either sign or zero fill.
module extender_NtoM #(
    parameter int N = 8,
    parameter int M = 32
) (
    input  logic [N-1:0] i_Data,
    input  logic         i_Sign,
    output logic [M-1:0] o_Data
);

    // Upper bits copy the MSB only when sign extension is requested.
    assign o_Data = {{(M-N){i_Sign & i_Data[N-1]}}, i_Data};

endmodule

// File: rtl/load_formatter.sv
// Load return path: collects one or two memory beats per request, aligns the
// addressed byte/halfword/word and returns a registered, extended result.
module load_formatter
    import haze_load_pkg::*;
#(
    parameter int p_TAG_W = 5
) (
    input  logic               i_CLK,
    input  logic               i_RSTn,
    input  logic               i_ReqValid,
    output logic               o_ReqReady,
    input  logic [2:0]         i_ReqFunct3,
    input  logic [1:0]         i_ReqAddrLo,
    input  logic [p_TAG_W-1:0] i_ReqTag,
    input  logic               i_MemValid,
    output logic               o_MemReady,
    input  logic [31:0]        i_MemData,
    output logic               o_SecondBeat,
    output logic               o_RspValid,
    input  logic               i_RspReady,
    output logic [31:0]        o_RspData,
    output logic [p_TAG_W-1:0] o_RspTag,
    output logic               o_RspIllegal
);

    load_state_e        state_q, state_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         addrlo_q, addrlo_d;
    logic [p_TAG_W-1:0] tag_q, tag_d;
    logic               illegal_q, illegal_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [p_TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic               rsp_illegal_q, rsp_illegal_d;

    logic               req_ready;
    logic               mem_ready;
    logic               req_fire;
    logic               mem_fire;
    logic               enter_resp;
    logic               sign_ext;
    logic [31:0]        win;
    logic [31:0]        ext8;
    logic [31:0]        ext16;
    logic [31:0]        result;

    // A new request can be taken when idle, or when the pending response leaves this cycle.
    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && i_RspReady);
    assign mem_ready = (state_q == BEAT1) || (state_q == BEAT2);
    assign req_fire  = i_ReqValid && req_ready;
    assign mem_fire  = i_MemValid && mem_ready;

    // Next-state and request/beat capture; a same-cycle accept overrides the RESP exit.
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        addrlo_d   = addrlo_q;
        tag_d      = tag_q;
        illegal_d  = illegal_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        enter_resp = 1'b0;

        case (state_q)
            BEAT1: begin
                if (mem_fire) begin
                    lo_d = i_MemData;
                    if (f_spans(funct3_q, addrlo_q)) begin
                        state_d = BEAT2;
                    end else begin
                        hi_d       = '0;
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            BEAT2: begin
                if (mem_fire) begin
                    hi_d       = i_MemData;
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (i_RspReady) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (req_fire) begin
            funct3_d  = i_ReqFunct3;
            addrlo_d  = i_ReqAddrLo;
            tag_d     = i_ReqTag;
            illegal_d = !f_is_legal(i_ReqFunct3);
            lo_d      = '0;
            hi_d      = '0;
            if (f_is_legal(i_ReqFunct3)) begin
                state_d = BEAT1;
            end else begin
                state_d    = RESP;
                enter_resp = 1'b1;
            end
        end
    end

    assign sign_ext = ~funct3_d[2];

    extender_NtoM #(.N(8), .M(32)) u_ext8 (
        .i_Data (win[7:0]),
        .i_Sign (sign_ext),
        .o_Data (ext8)
    );

    extender_NtoM #(.N(16), .M(32)) u_ext16 (
        .i_Data (win[15:0]),
        .i_Sign (sign_ext),
        .o_Data (ext16)
    );

    // Align the beat pair on the incoming values and load the response registers on RESP entry.
    always_comb begin
        win           = 32'({hi_d, lo_d} >> {addrlo_d, 3'b000});
        rsp_data_d    = rsp_data_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_illegal_d = rsp_illegal_q;

        case (funct3_d)
            LB, LBU: result = ext8;
            LH, LHU: result = ext16;
            LW:      result = win;
            default: result = '0;
        endcase

        if (enter_resp) begin
            rsp_data_d    = illegal_d ? 32'h0 : result;
            rsp_tag_d     = tag_d;
            rsp_illegal_d = illegal_d;
        end
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q       <= IDLE;
            funct3_q      <= '0;
            addrlo_q      <= '0;
            tag_q         <= '0;
            illegal_q     <= 1'b0;
            lo_q          <= '0;
            hi_q          <= '0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            funct3_q      <= funct3_d;
            addrlo_q      <= addrlo_d;
            tag_q         <= tag_d;
            illegal_q     <= illegal_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign o_ReqReady   = req_ready;
    assign o_MemReady   = mem_ready;
    assign o_SecondBeat = (state_q == BEAT2);
    assign o_RspValid   = (state_q == RESP);
    assign o_RspData    = rsp_data_q;
    assign o_RspTag     = rsp_tag_q;
    assign o_RspIllegal = rsp_illegal_q;

endmodule

// File: tb/tb_load_formatter.sv
// Self-checking bench for load_formatter: directed cases plus randomized loads
// compared against a byte-level reference model.
module tb_load_formatter;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [1:0]  req_addrlo;
    logic [4:0]  req_tag;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        second_beat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        rsp_illegal;

    int errors = 0;
    int checks = 0;

    load_formatter #(.p_TAG_W(5)) dut (
        .i_CLK        (clk),
        .i_RSTn       (rst_n),
        .i_ReqValid   (req_valid),
        .o_ReqReady   (req_ready),
        .i_ReqFunct3  (req_funct3),
        .i_ReqAddrLo  (req_addrlo),
        .i_ReqTag     (req_tag),
        .i_MemValid   (mem_valid),
        .o_MemReady   (mem_ready),
        .i_MemData    (mem_data),
        .o_SecondBeat (second_beat),
        .o_RspValid   (rsp_valid),
        .i_RspReady   (rsp_ready),
        .o_RspData    (rsp_data),
        .o_RspTag     (rsp_tag),
        .o_RspIllegal (rsp_illegal)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Byte-level model: gather the addressed bytes from the two words, then extend.
    function automatic void ref_load(input logic [2:0] f3, input logic [1:0] a,
                                     input logic [31:0] w0, input logic [31:0] w1,
                                     output logic [31:0] data, output logic ill, output int nb);
        logic [7:0] mem [8];
        int         size;
        longint     v;
        for (int i = 0; i < 4; i++) begin
            mem[i]     = w0[8*i +: 8];
            mem[i + 4] = w1[8*i +: 8];
        end
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        data = 32'h0;
        ill  = (size == 0);
        nb   = 0;
        if (!ill) begin
            nb = (int'(a) + size > 4) ? 2 : 1;
            v  = 0;
            for (int i = 0; i < size; i++)
                v += longint'(mem[int'(a) + i]) << (8 * i);
            if (!f3[2] && mem[int'(a) + size - 1][7])
                v = v - (longint'(1) << (8 * size));
            data = v[31:0];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, offers beats (with optional stalls) and returns when the
    // response is seen, sampled at the negedge of the response cycle. Cycle 0 is the
    // accept cycle.
    task automatic run_load(input logic [2:0] f3, input logic [1:0] a, input logic [4:0] tag,
                            input logic [31:0] w0, input logic [31:0] w1, input int stall,
                            output logic [31:0] data, output logic [4:0] tag_o, output logic ill,
                            output int lat, output int beats, output int sb_cycle);
        int cyc;
        int wait_cnt;
        data     = 32'h0;
        tag_o    = 5'h0;
        ill      = 1'b0;
        lat      = -1;
        beats    = 0;
        sb_cycle = -1;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addrlo = a;
        req_tag    = tag;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) break;
            step();
        end
        step();
        req_valid = 1'b0;
        cyc       = 1;
        wait_cnt  = 0;
        for (int k = 0; k < 60; k++) begin
            mem_valid = (wait_cnt >= stall);
            mem_data  = (beats == 0) ? w0 : w1;
            @(negedge clk);
            if (second_beat && sb_cycle < 0) sb_cycle = cyc;
            if (rsp_valid) begin
                data  = rsp_data;
                tag_o = rsp_tag;
                ill   = rsp_illegal;
                lat   = cyc;
                break;
            end
            if (mem_valid && mem_ready) begin
                beats++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
            step();
            cyc++;
        end
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_ready: got %b expected 0", mem_ready); end
        checks++; if (second_beat !== 1'b0) begin errors++; $display("[TB] FAIL reset_second_beat: got %b expected 0", second_beat); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_illegal: got %b expected 0", rsp_illegal); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 00000000", rsp_data); end
        checks++; if (rsp_tag !== 5'h0) begin errors++; $display("[TB] FAIL reset_rsp_tag: got %h expected 00", rsp_tag); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_byte();
        logic [31:0] d; logic [4:0] t; logic il; int lat, nb, sb;
        run_load(3'b000, 2'd3, 5'd1, 32'h80123456, 32'h0, 0, d, t, il, lat, nb, sb);
        checks++; if (d !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_data: got %h expected ffffff80", d); end
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL lb_latency: got %0d expected 2", lat); end
        checks++; if (nb !== 1) begin errors++; $display("[TB] FAIL lb_beats: got %0d expected 1", nb); end
        step();
        run_load(3'b100, 2'd3, 5'd2, 32'h80123456, 32'h0, 0, d, t, il, lat, nb, sb);
        checks++; if (d !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_data: got %h expected 00000080", d); end
        checks++; if (t !== 5'd2) begin errors++; $display("[TB] FAIL lbu_tag: got %0d expected 2", t); end
        step();
    endtask

    task automatic test_half();
        logic [31:0] d; logic [4:0] t; logic il; int lat, nb, sb;
        run_load(3'b001, 2'd3, 5'd5, 32'hAB000000, 32'h000000CD, 0, d, t, il, lat, nb, sb);
        checks++; if (sb !== 2) begin errors++; $display("[TB] FAIL lh_second_beat_cycle: got %0d expected 2", sb); end
        checks++; if (d !== 32'hFFFFCDAB) begin errors++; $display("[TB] FAIL lh_data: got %h expected ffffcdab", d); end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL lh_latency: got %0d expected 3", lat); end
        checks++; if (nb !== 2) begin errors++; $display("[TB] FAIL lh_beats: got %0d expected 2", nb); end
        step();
        run_load(3'b101, 2'd3, 5'd6, 32'hAB000000, 32'h000000CD, 0, d, t, il, lat, nb, sb);
        checks++; if (d !== 32'h0000CDAB) begin errors++; $display("[TB] FAIL lhu_data: got %h expected 0000cdab", d); end
        step();
    endtask

    task automatic test_word();
        logic [31:0] d; logic [4:0] t; logic il; int lat, nb, sb;
        run_load(3'b010, 2'd2, 5'd8, 32'h56781234, 32'hDEAD9ABC, 0, d, t, il, lat, nb, sb);
        checks++; if (d !== 32'h9ABC5678) begin errors++; $display("[TB] FAIL lw_split_data: got %h expected 9abc5678", d); end
        checks++; if (nb !== 2) begin errors++; $display("[TB] FAIL lw_split_beats: got %0d expected 2", nb); end
        step();
        run_load(3'b010, 2'd0, 5'd9, 32'h01020304, 32'hFFFFFFFF, 0, d, t, il, lat, nb, sb);
        checks++; if (d !== 32'h01020304) begin errors++; $display("[TB] FAIL lw_aligned_data: got %h expected 01020304", d); end
        checks++; if (nb !== 1) begin errors++; $display("[TB] FAIL lw_aligned_beats: got %0d expected 1", nb); end
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL lw_aligned_latency: got %0d expected 2", lat); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [4:0] t; logic il; int lat, nb, sb;
        rsp_ready = 1'b0;
        run_load(3'b001, 2'd3, 5'd9, 32'hAB000000, 32'h000000CD, 1, d, t, il, lat, nb, sb);
        checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected 5", lat); end
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid: got %b expected 1", rsp_valid); end
            checks++; if (rsp_data !== 32'hFFFFCDAB) begin errors++; $display("[TB] FAIL hold_data: got %h expected ffffcdab", rsp_data); end
            checks++; if (rsp_tag !== 5'd9) begin errors++; $display("[TB] FAIL hold_tag: got %0d expected 9", rsp_tag); end
        end
        step();
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        req_funct3 = 3'b000;
        req_addrlo = 2'd3;
        req_tag    = 5'd4;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_req_ready: got %b expected 1", req_ready); end
        step();
        req_valid = 1'b0;
        mem_valid = 1'b1;
        mem_data  = 32'h80123456;
        @(negedge clk);
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_mem_ready: got %b expected 1", mem_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rsp_dropped: got %b expected 0", rsp_valid); end
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_data !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL b2b_data: got %h expected ffffff80", rsp_data); end
        checks++; if (rsp_tag !== 5'd4) begin errors++; $display("[TB] FAIL b2b_tag: got %0d expected 4", rsp_tag); end
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] d; logic [4:0] t; logic il; int lat, nb, sb;
        run_load(3'b011, 2'd1, 5'd7, 32'h12345678, 32'h9ABCDEF0, 0, d, t, il, lat, nb, sb);
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL illegal_latency: got %0d expected 1", lat); end
        checks++; if (nb !== 0) begin errors++; $display("[TB] FAIL illegal_beats: got %0d expected 0", nb); end
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL illegal_data: got %h expected 00000000", d); end
        checks++; if (il !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag: got %b expected 1", il); end
        checks++; if (t !== 5'd7) begin errors++; $display("[TB] FAIL illegal_tag: got %0d expected 7", t); end
        step();
    endtask

    task automatic test_stray_beat();
        logic [31:0] d; logic [4:0] t; logic il; int lat, nb, sb;
        mem_valid = 1'b1;
        mem_data  = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL stray_mem_ready: got %b expected 0", mem_ready); end
            step();
        end
        mem_valid = 1'b0;
        run_load(3'b010, 2'd0, 5'd3, 32'hCAFEF00D, 32'h0, 0, d, t, il, lat, nb, sb);
        checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL stray_next_data: got %h expected cafef00d", d); end
        checks++; if (il !== 1'b0) begin errors++; $display("[TB] FAIL stray_next_illegal: got %b expected 0", il); end
        step();
    endtask

    task automatic test_random();
        logic [2:0]  legal [5];
        logic [2:0]  bad [3];
        logic [2:0]  f3;
        logic [1:0]  a;
        logic [4:0]  tag;
        logic [31:0] w0, w1, d, exp_d;
        logic [4:0]  t;
        logic        il, exp_il;
        int          lat, nb, sb, exp_nb, stall, exp_lat;
        legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010; legal[3] = 3'b100; legal[4] = 3'b101;
        bad[0] = 3'b011; bad[1] = 3'b110; bad[2] = 3'b111;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) f3 = bad[$urandom_range(0, 2)];
            else                           f3 = legal[$urandom_range(0, 4)];
            a     = 2'($urandom_range(0, 3));
            tag   = 5'($urandom);
            w0    = $urandom;
            w1    = $urandom;
            stall = $urandom_range(0, 2);
            ref_load(f3, a, w0, w1, exp_d, exp_il, exp_nb);
            exp_lat = 1 + exp_nb * (1 + stall);
            run_load(f3, a, tag, w0, w1, stall, d, t, il, lat, nb, sb);
            checks++; if (d !== exp_d) begin errors++; $display("[TB] FAIL rand_data f3=%b a=%0d: got %h expected %h", f3, a, d, exp_d); end
            checks++; if (t !== tag) begin errors++; $display("[TB] FAIL rand_tag: got %0d expected %0d", t, tag); end
            checks++; if (il !== exp_il) begin errors++; $display("[TB] FAIL rand_illegal f3=%b: got %b expected %b", f3, il, exp_il); end
            checks++; if (lat !== exp_lat) begin errors++; $display("[TB] FAIL rand_latency f3=%b a=%0d: got %0d expected %0d", f3, a, lat, exp_lat); end
            checks++; if (nb !== exp_nb) begin errors++; $display("[TB] FAIL rand_beats f3=%b a=%0d: got %0d expected %0d", f3, a, nb, exp_nb); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [4:0] t; logic il; int lat, nb, sb;
        run_load(3'b100, 2'd0, 5'd11, 32'h000000FF, 32'h0, 0, d, t, il, lat, nb, sb);
        checks++; if (d !== 32'h000000FF) begin errors++; $display("[TB] FAIL pre_reset_data: got %h expected 000000ff", d); end
        step();
        req_valid  = 1'b1;
        req_funct3 = 3'b010;
        req_addrlo = 2'd1;
        req_tag    = 5'd3;
        step();
        req_valid = 1'b0;
        mem_valid = 1'b1;
        mem_data  = 32'h11111111;
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        checks++; if (second_beat !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_beat2: got %b expected 1", second_beat); end
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_req_ready: got %b expected 1", req_ready); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_mem_ready: got %b expected 0", mem_ready); end
        checks++; if (second_beat !== 1'b0) begin errors++; $display("[TB] FAIL mid_second_beat: got %b expected 0", second_beat); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL mid_rsp_data: got %h expected 00000000", rsp_data); end
        checks++; if (rsp_tag !== 5'h0) begin errors++; $display("[TB] FAIL mid_rsp_tag: got %0d expected 0", rsp_tag); end
        checks++; if (rsp_illegal !== 1'b0) begin errors++; $display("[TB] FAIL mid_rsp_illegal: got %b expected 0", rsp_illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_valid = 1'b1;
        mem_data  = 32'h22222222;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_response: got %b expected 0", rsp_valid); end
        end
        mem_valid = 1'b0;
        step();
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = 3'b000;
        req_addrlo = 2'd0;
        req_tag    = 5'd0;
        mem_valid  = 1'b0;
        mem_data   = 32'h0;
        rsp_ready  = 1'b1;
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_back_to_back();
        test_illegal();
        test_stray_beat();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
